// File: rtl/a4_stream_fifo.sv
// Level-4 approximation sample buffer: captures a4_0 every din_valid cycle and
// presents it on a valid/ready stream with a frame marker; overflow drops are counted.
module a4_stream_fifo #(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 256,
  parameter int DROP_W    = 16
) (
  input  logic                      clk_78_125,
  input  logic                      rst,
  input  logic                      din_valid,
  input  logic [31:0]               a4_0,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [31:0]               m_data,
  output logic                      m_last,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt,
  input  logic                      ovf_clr
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int RAM_D = DEPTH - 1;
  localparam int FW    = $clog2(FRAME_LEN);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST  = AW'(RAM_D - 1);
  localparam logic [FW-1:0] FRAME_END = FW'(FRAME_LEN - 1);

  logic [32:0]   ram [RAM_D];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] frame_cnt;

  logic pop;
  logic accept;
  logic drop;
  logic load;
  logic ram_empty;
  logic tag_last;
  logic ram_rd;
  logic ram_wr;

  always_comb begin
    pop       = m_valid && m_ready;
    accept    = din_valid && ((fifo_count < FULL_CNT) || pop);
    drop      = din_valid && !accept;
    load      = !m_valid || pop;
    ram_empty = (fifo_count == CW'(m_valid));
    tag_last  = (frame_cnt == FRAME_END);
    ram_rd    = load && !ram_empty;
    // an accepted sample skips the RAM only when it goes straight to the output register
    ram_wr    = accept && !(load && ram_empty);
  end

  always_ff @(posedge clk_78_125) begin
    if (ram_wr) ram[wr_ptr] <= {tag_last, a4_0};
  end

  always_ff @(posedge clk_78_125 or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      frame_cnt  <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (accept) frame_cnt <= tag_last ? '0 : frame_cnt + 1'b1;
      if (ram_wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (ram_rd) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

      if (load) begin
        if (ram_rd)      {m_last, m_data} <= ram[rd_ptr];
        else if (accept) {m_last, m_data} <= {tag_last, a4_0};
        m_valid <= ram_rd || accept;
      end

      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // a drop in the same cycle as a clear restarts the count at one
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_clr)              drop_cnt <= DROP_W'(1);
        else if (drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule
